// File: rtl/param_loader_pkg.sv
// Shared types and default network shape for the parameter loader.
// The per-layer counts default to the NUM_NEURON_Lx / NUM_WEIGHT_Lx macros;
// fallback values are supplied here when the build does not define them.

`ifndef NUM_NEURON_L1
`define NUM_NEURON_L1 2
`endif
`ifndef NUM_NEURON_L2
`define NUM_NEURON_L2 2
`endif
`ifndef NUM_NEURON_L3
`define NUM_NEURON_L3 1
`endif
`ifndef NUM_NEURON_L4
`define NUM_NEURON_L4 1
`endif
`ifndef NUM_WEIGHT_L1
`define NUM_WEIGHT_L1 3
`endif
`ifndef NUM_WEIGHT_L2
`define NUM_WEIGHT_L2 2
`endif
`ifndef NUM_WEIGHT_L3
`define NUM_WEIGHT_L3 2
`endif
`ifndef NUM_WEIGHT_L4
`define NUM_WEIGHT_L4 1
`endif

package param_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WEIGHT = 2'd1,
    ST_BIAS   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_LAYERS = 4;

  // Default per-layer shape, indexed by layer number 1..4.
  localparam int unsigned DEF_NUM_NEURON [1:4] = '{`NUM_NEURON_L1, `NUM_NEURON_L2,
                                                   `NUM_NEURON_L3, `NUM_NEURON_L4};
  localparam int unsigned DEF_NUM_WEIGHT [1:4] = '{`NUM_WEIGHT_L1, `NUM_WEIGHT_L2,
                                                   `NUM_WEIGHT_L3, `NUM_WEIGHT_L4};

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_loader.sv
// Streams weights and biases for a four-layer network from one AXI-stream
// style input and broadcasts each word, tagged with its layer/neuron, one
// cycle after it is accepted.
//
// Handshake: a word transfers on a rising edge where i_s_axis_valid and
// o_s_axis_ready are both 1. o_s_axis_ready comes only from the registered
// state (1 in WEIGHT and BIAS) and never looks at i_s_axis_valid, so the
// producer may hold valid for as long as it likes; cycles with valid=0 are
// simply skipped without losing the load position.

module param_loader
  import param_loader_pkg::*;
#(
  parameter int unsigned NUM_NEURON_L1 = `NUM_NEURON_L1,
  parameter int unsigned NUM_NEURON_L2 = `NUM_NEURON_L2,
  parameter int unsigned NUM_NEURON_L3 = `NUM_NEURON_L3,
  parameter int unsigned NUM_NEURON_L4 = `NUM_NEURON_L4,
  parameter int unsigned NUM_WEIGHT_L1 = `NUM_WEIGHT_L1,
  parameter int unsigned NUM_WEIGHT_L2 = `NUM_WEIGHT_L2,
  parameter int unsigned NUM_WEIGHT_L3 = `NUM_WEIGHT_L3,
  parameter int unsigned NUM_WEIGHT_L4 = `NUM_WEIGHT_L4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_s_axis_data,
  input  logic        i_s_axis_valid,
  output logic        o_s_axis_ready,
  output logic [31:0] o_weight,
  output logic        o_weight_valid,
  output logic [31:0] o_bias,
  output logic        o_bias_valid,
  output logic [31:0] o_layer_id,
  output logic [31:0] o_neuron_id,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_loaded
);

  localparam int unsigned MAX_N = max4(NUM_NEURON_L1, NUM_NEURON_L2, NUM_NEURON_L3, NUM_NEURON_L4);
  localparam int unsigned MAX_W = max4(NUM_WEIGHT_L1, NUM_WEIGHT_L2, NUM_WEIGHT_L3, NUM_WEIGHT_L4);
  localparam int unsigned NCW   = cnt_width(MAX_N);
  localparam int unsigned WCW   = cnt_width(MAX_W);

  function automatic int unsigned neurons_of(input logic [2:0] l);
    case (l)
      3'd1:    return NUM_NEURON_L1;
      3'd2:    return NUM_NEURON_L2;
      3'd3:    return NUM_NEURON_L3;
      default: return NUM_NEURON_L4;
    endcase
  endfunction

  function automatic int unsigned weights_of(input logic [2:0] l);
    case (l)
      3'd1:    return NUM_WEIGHT_L1;
      3'd2:    return NUM_WEIGHT_L2;
      3'd3:    return NUM_WEIGHT_L3;
      default: return NUM_WEIGHT_L4;
    endcase
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       layer;   // 1..4 while loading, 0 otherwise
  logic [NCW-1:0]   neuron;
  logic [WCW-1:0]   wcnt;
  logic             accept;
  logic             last_weight;
  logic             last_neuron;
  logic             last_layer;

  assign last_weight = (32'(wcnt) == weights_of(layer) - 32'd1);
  assign last_neuron = (32'(neuron) == neurons_of(layer) - 32'd1);
  assign last_layer  = (layer == 3'd4);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_start) state_nxt = ST_WEIGHT;
      ST_WEIGHT: if (accept && last_weight) state_nxt = ST_BIAS;
      ST_BIAS:   if (accept) state_nxt = (last_neuron && last_layer) ? ST_DONE : ST_WEIGHT;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs and the transfer qualifier.
  always_comb begin
    o_s_axis_ready = (state == ST_WEIGHT) || (state == ST_BIAS);
    o_busy         = (state != ST_IDLE);
    accept         = i_s_axis_valid && o_s_axis_ready;
  end

  // Load-position counters; layer drops to 0 as the final bias is taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      layer  <= 3'd0;
      neuron <= '0;
      wcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            layer  <= 3'd1;
            neuron <= '0;
            wcnt   <= '0;
          end
        end
        ST_WEIGHT: begin
          if (accept) wcnt <= last_weight ? '0 : wcnt + 1'b1;
        end
        ST_BIAS: begin
          if (accept) begin
            if (last_neuron) begin
              neuron <= '0;
              layer  <= last_layer ? 3'd0 : layer + 3'd1;
            end else begin
              neuron <= neuron + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered broadcast: each strobe carries the IDs in force when its word was taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_weight       <= '0;
      o_weight_valid <= 1'b0;
      o_bias         <= '0;
      o_bias_valid   <= 1'b0;
      o_layer_id     <= '0;
      o_neuron_id    <= '0;
      o_done         <= 1'b0;
      o_loaded       <= 1'b0;
    end else begin
      o_weight_valid <= accept && (state == ST_WEIGHT);
      o_bias_valid   <= accept && (state == ST_BIAS);
      if (accept && (state == ST_WEIGHT)) o_weight <= i_s_axis_data;
      if (accept && (state == ST_BIAS))   o_bias   <= i_s_axis_data;
      o_layer_id  <= {29'd0, layer};
      o_neuron_id <= 32'(neuron);
      o_done      <= (state == ST_DONE);
      if ((state == ST_IDLE) && i_start) o_loaded <= 1'b0;
      else if (state == ST_DONE)         o_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader with network shape neurons 2,2,1,1 and
// weights 3,2,2,1 (19 words per load).

module tb_param_loader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_s_axis_data;
  logic        i_s_axis_valid;
  logic        o_s_axis_ready;
  logic [31:0] o_weight;
  logic        o_weight_valid;
  logic [31:0] o_bias;
  logic        o_bias_valid;
  logic [31:0] o_layer_id;
  logic [31:0] o_neuron_id;
  logic        o_busy;
  logic        o_done;
  logic        o_loaded;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  // Hand-derived load order for words 1..19.
  bit exp_is_bias [19] = '{0,0,0,1, 0,0,0,1, 0,0,1, 0,0,1, 0,0,1, 0,1};
  int exp_layer   [19] = '{1,1,1,1, 1,1,1,1, 2,2,2, 2,2,2, 3,3,3, 4,4};
  int exp_neuron  [19] = '{0,0,0,0, 1,1,1,1, 0,0,0, 1,1,1, 0,0,0, 0,0};

  param_loader #(
    .NUM_NEURON_L1(2), .NUM_NEURON_L2(2), .NUM_NEURON_L3(1), .NUM_NEURON_L4(1),
    .NUM_WEIGHT_L1(3), .NUM_WEIGHT_L2(2), .NUM_WEIGHT_L3(2), .NUM_WEIGHT_L4(1)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (i_start),
    .i_s_axis_data  (i_s_axis_data),
    .i_s_axis_valid (i_s_axis_valid),
    .o_s_axis_ready (o_s_axis_ready),
    .o_weight       (o_weight),
    .o_weight_valid (o_weight_valid),
    .o_bias         (o_bias),
    .o_bias_valid   (o_bias_valid),
    .o_layer_id     (o_layer_id),
    .o_neuron_id    (o_neuron_id),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_loaded       (o_loaded)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check1({tag, "_wvalid"}, o_weight_valid, 1'b0);
    check1({tag, "_bvalid"}, o_bias_valid, 1'b0);
  endtask

  // One load: start pulse then n_words words (optionally gapped, optionally
  // with a stray start at word 10); full loads also check the completion tail.
  task automatic run_load(input bit toggle, input bit pulse_mid, input int n_words);
    int          wi;
    int          cyc;
    bit          v;
    logic [31:0] exp_word;
    exp_q.delete();
    for (int k = 1; k <= n_words; k++) exp_q.push_back(32'(k));
    i_s_axis_valid = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check1("busy_after_start", o_busy, 1'b1);
    check1("loaded_cleared", o_loaded, 1'b0);
    check_quiet("after_start");
    wi  = 0;
    cyc = 0;
    while (wi < n_words && cyc < 200) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      i_s_axis_valid = v;
      i_s_axis_data  = 32'(wi + 1);
      i_start        = pulse_mid && (wi == 9) && v;
      check1("ready_in_load", o_s_axis_ready, 1'b1);
      tick();
      cyc++;
      i_start = 1'b0;
      if (v) begin
        check1("weight_valid", o_weight_valid, !exp_is_bias[wi]);
        check1("bias_valid", o_bias_valid, exp_is_bias[wi]);
        if (exp_q.size() == 0) begin
          check1("exp_q_underflow", 1'b1, 1'b0);
        end else begin
          exp_word = exp_q.pop_front();
          if (exp_is_bias[wi]) check32("bias_data", o_bias, exp_word);
          else                 check32("weight_data", o_weight, exp_word);
        end
        check32("layer_id", o_layer_id, 32'(exp_layer[wi]));
        check32("neuron_id", o_neuron_id, 32'(exp_neuron[wi]));
        wi++;
      end else begin
        check_quiet("gap");
      end
    end
    check1("load_in_budget", cyc < 200, 1'b1);
    i_s_axis_valid = 1'b0;
    if (n_words == 19) begin
      check1("done_not_with_bias", o_done, 1'b0);
      check1("busy_in_done", o_busy, 1'b1);
      tick();
      check1("done_pulse", o_done, 1'b1);
      check1("busy_off", o_busy, 1'b0);
      check32("layer_zero", o_layer_id, 32'd0);
      check32("neuron_zero", o_neuron_id, 32'd0);
      check_quiet("done_cycle");
      tick();
      check1("done_one_cycle", o_done, 1'b0);
      check1("loaded_set", o_loaded, 1'b1);
      check32("layer_zero_idle", o_layer_id, 32'd0);
      check1("ready_idle", o_s_axis_ready, 1'b0);
      check1("exp_q_empty", exp_q.size() == 0, 1'b1);
    end
  endtask

  // Directed sequence.
  initial begin
    rst            = 1'b1;
    i_start        = 1'b0;
    i_s_axis_valid = 1'b0;
    i_s_axis_data  = '0;
    tick();
    tick();
    check1("rst_ready", o_s_axis_ready, 1'b0);
    check1("rst_busy", o_busy, 1'b0);
    check1("rst_done", o_done, 1'b0);
    check1("rst_loaded", o_loaded, 1'b0);
    check32("rst_layer", o_layer_id, 32'd0);
    check32("rst_weight", o_weight, 32'd0);
    check_quiet("rst");
    rst = 1'b0;

    // Valid offered while idle with no start: nothing taken.
    i_s_axis_valid = 1'b1;
    i_s_axis_data  = 32'hdead_beef;
    tick();
    check1("idle_ready", o_s_axis_ready, 1'b0);
    check_quiet("idle_valid");
    tick();
    check_quiet("idle_valid2");
    check1("idle_busy", o_busy, 1'b0);
    i_s_axis_valid = 1'b0;

    // Back-to-back load.
    run_load(1'b0, 1'b0, 19);

    // Valid toggling every cycle.
    run_load(1'b1, 1'b0, 19);

    // Abandon after word 6, with a word offered during reset.
    run_load(1'b0, 1'b0, 6);
    rst            = 1'b1;
    i_s_axis_valid = 1'b1;
    i_s_axis_data  = 32'd7;
    tick();
    rst            = 1'b0;
    i_s_axis_valid = 1'b0;
    check_quiet("after_reset");
    check1("ar_ready", o_s_axis_ready, 1'b0);
    check1("ar_busy", o_busy, 1'b0);
    check1("ar_done", o_done, 1'b0);
    check1("ar_loaded", o_loaded, 1'b0);
    check32("ar_weight", o_weight, 32'd0);
    check32("ar_bias", o_bias, 32'd0);
    check32("ar_layer", o_layer_id, 32'd0);
    check32("ar_neuron", o_neuron_id, 32'd0);
    tick();
    check_quiet("after_reset2");
    run_load(1'b0, 1'b0, 19);

    // Stray start during the load.
    run_load(1'b0, 1'b1, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
